// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, forwarding select codes, the PC register index and the
// packed stage-control word with its canonical values.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef struct packed {
        logic pc_le;
        logic if_id_le;
        logic id_ex_le;
        logic ex_mem_le;
        logic if_id_flush;
        logic id_ex_nop;
    } pipe_ctrl_t;

    // Normal advance of every stage.
    localparam pipe_ctrl_t CTRL_RUN    = '{pc_le: 1'b1, if_id_le: 1'b1, id_ex_le: 1'b1,
                                           ex_mem_le: 1'b1, if_id_flush: 1'b0, id_ex_nop: 1'b0};
    // Whole pipeline frozen behind a slow memory access.
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_le: 1'b0, if_id_le: 1'b0, id_ex_le: 1'b0,
                                           ex_mem_le: 1'b0, if_id_flush: 1'b0, id_ex_nop: 1'b0};
    // Load-use bubble: hold PC and IF/ID, push a NOP into ID/EX.
    localparam pipe_ctrl_t CTRL_STALL  = '{pc_le: 1'b0, if_id_le: 1'b0, id_ex_le: 1'b1,
                                           ex_mem_le: 1'b1, if_id_flush: 1'b0, id_ex_nop: 1'b1};
    // Values presented while reset is held.
    localparam pipe_ctrl_t CTRL_RESET  = '{pc_le: 1'b0, if_id_le: 1'b0, id_ex_le: 1'b0,
                                           ex_mem_le: 1'b0, if_id_flush: 1'b0, id_ex_nop: 1'b1};

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ID-stage source operand. Youngest producer
// wins (EX, then MEM, then WB); R15 is the PC and always comes from the
// register file path. A load in EX cannot forward (its data is not ready).
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_rf_en_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_rf_en_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_rf_en_i,
    output logic [1:0]        fwd_o
);

    // Priority compare against the three in-flight destinations.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned (which would infer a latch).
        fwd_o = FWD_RF;
        if (use_i && (rs_i != REG_AW'(PC_REG))) begin
            if (ex_rf_en_i && !ex_load_i && (ex_rd_i == rs_i)) begin
                fwd_o = FWD_EX;
            end else if (mem_rf_en_i && (mem_rd_i == rs_i)) begin
                fwd_o = FWD_MEM;
            end else if (wb_rf_en_i && (wb_rd_i == rs_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core: stage load-enables,
// IF/ID flush on taken branches, ID/EX NOP injection on load-use, operand
// forwarding selects, and a freeze with timeout while data memory is busy.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 15
`ifdef HAZ_STATS_EN
   ,parameter int CNT_W       = 16
`endif
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic [REG_AW-1:0] ID_Rn,
    input  logic [REG_AW-1:0] ID_Rm,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_use_Rn,
    input  logic              ID_use_Rm,
    input  logic              ID_use_Rd,
    input  logic [REG_AW-1:0] EX_Rd,
    input  logic [REG_AW-1:0] MEM_Rd,
    input  logic [REG_AW-1:0] WB_Rd,
    input  logic              EX_RF_enable,
    input  logic              MEM_RF_enable,
    input  logic              WB_RF_enable,
    input  logic              EX_load_instr,
    input  logic              ID_branch_taken,
    input  logic              MEM_req,
    input  logic              MEM_ready,
    output logic              PC_LE,
    output logic              IF_ID_LE,
    output logic              ID_EX_LE,
    output logic              EX_MEM_LE,
    output logic              IF_ID_flush,
    output logic              ID_EX_nop,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B,
    output logic [1:0]        fwd_C,
    output logic              mem_error
`ifdef HAZ_STATS_EN
   ,output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    pipe_ctrl_t        ctrl;
    logic [1:0]        fwd_a_raw, fwd_b_raw, fwd_c_raw;
    logic              hit_rn, hit_rm, hit_rd, load_use, timeout;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0]  stall_count_q, flush_count_q;
`endif

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_i(ID_Rn), .use_i(ID_use_Rn),
        .ex_rd_i(EX_Rd), .ex_rf_en_i(EX_RF_enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Rd), .mem_rf_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_rf_en_i(WB_RF_enable), .fwd_o(fwd_a_raw)
    );
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_i(ID_Rm), .use_i(ID_use_Rm),
        .ex_rd_i(EX_Rd), .ex_rf_en_i(EX_RF_enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Rd), .mem_rf_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_rf_en_i(WB_RF_enable), .fwd_o(fwd_b_raw)
    );
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_c (
        .rs_i(ID_Rd), .use_i(ID_use_Rd),
        .ex_rd_i(EX_Rd), .ex_rf_en_i(EX_RF_enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Rd), .mem_rf_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_rf_en_i(WB_RF_enable), .fwd_o(fwd_c_raw)
    );

    // A load in EX whose destination is read by the instruction in ID.
    assign hit_rn   = ID_use_Rn && (ID_Rn != REG_AW'(PC_REG)) && (ID_Rn == EX_Rd);
    assign hit_rm   = ID_use_Rm && (ID_Rm != REG_AW'(PC_REG)) && (ID_Rm == EX_Rd);
    assign hit_rd   = ID_use_Rd && (ID_Rd != REG_AW'(PC_REG)) && (ID_Rd == EX_Rd);
    assign load_use = EX_load_instr && EX_RF_enable && (hit_rn || hit_rm || hit_rd);
    assign timeout  = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

    // Next-state and stage-control decode from current state and inputs.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        ctrl        = CTRL_RUN;
        unique case (state_q)
            RUN: begin
                if (MEM_req && !MEM_ready) begin
                    // The entry cycle is the first wait cycle.
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (load_use) begin
                    // Stall wins over a coincident branch; it is re-evaluated next cycle.
                    ctrl    = CTRL_STALL;
                    state_d = LD_STALL;
                end else if (ID_branch_taken) begin
                    ctrl.if_id_flush = 1'b1;
                end
            end
            LD_STALL: begin
                ctrl.if_id_flush = ID_branch_taken;
                state_d          = RUN;
            end
            MEM_WAIT: begin
                if (MEM_ready || timeout) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (!MEM_ready) begin
                        mem_error_d = 1'b1;
                    end
                end else begin
                    // Release happens at MEM_TIMEOUT, so the count never passes it.
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Reset overrides the decode asynchronously.
        if (!R_n) begin
            ctrl = CTRL_RESET;
        end
    end

    // State, wait counter, sticky error and optional statistics.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_error_q   <= 1'b0;
`ifdef HAZ_STATS_EN
            stall_count_q <= '0;
            flush_count_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
`ifdef HAZ_STATS_EN
            if (!ctrl.pc_le && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (ctrl.if_id_flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
`endif
        end
    end

    assign PC_LE       = ctrl.pc_le;
    assign IF_ID_LE    = ctrl.if_id_le;
    assign ID_EX_LE    = ctrl.id_ex_le;
    assign EX_MEM_LE   = ctrl.ex_mem_le;
    assign IF_ID_flush = ctrl.if_id_flush;
    assign ID_EX_nop   = ctrl.id_ex_nop;
    assign fwd_A       = R_n ? fwd_a_raw : FWD_RF;
    assign fwd_B       = R_n ? fwd_b_raw : FWD_RF;
    assign fwd_C       = R_n ? fwd_c_raw : FWD_RF;
    assign mem_error   = mem_error_q;

`ifdef HAZ_STATS_EN
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a table of single-cycle forwarding
// and branch vectors, then hand-written load-use, branch/stall, memory
// wait, timeout and asynchronous reset sequences.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       R_n;
    logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
    logic       ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic       EX_load_instr, ID_branch_taken, MEM_req, MEM_ready;
    logic       PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, IF_ID_flush, ID_EX_nop;
    logic [1:0] fwd_A, fwd_B, fwd_C;
    logic       mem_error;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    hazard_ctrl_unit dut (
        .clk(clk), .R_n(R_n),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
        .EX_load_instr(EX_load_instr), .ID_branch_taken(ID_branch_taken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_EX_LE(ID_EX_LE), .EX_MEM_LE(EX_MEM_LE),
        .IF_ID_flush(IF_ID_flush), .ID_EX_nop(ID_EX_nop),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C),
        .mem_error(mem_error)
`ifdef HAZ_STATS_EN
       ,.stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    // {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_nop}
    logic [4:0] le_vec;
    assign le_vec = {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_nop};

    localparam logic [4:0] LE_RUN    = 5'b11110;
    localparam logic [4:0] LE_FREEZE = 5'b00000;
    localparam logic [4:0] LE_STALL  = 5'b00111;
    localparam logic [4:0] LE_RESET  = 5'b00001;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] rn, rm, rd;
        logic [2:0] use3;   // {Rn, Rm, Rd}
        logic [3:0] ex_rd, mem_rd, wb_rd;
        logic [2:0] en3;    // {EX, MEM, WB}
        logic       ex_ld, br;
        logic [1:0] ea, eb, ec;
        logic       eflush;
    } vec_t;

    function automatic vec_t mk(input string name,
                                input logic [3:0] rn, rm, rd, input logic [2:0] use3,
                                input logic [3:0] ex_rd, mem_rd, wb_rd, input logic [2:0] en3,
                                input logic ex_ld, br,
                                input logic [1:0] ea, eb, ec, input logic eflush);
        vec_t v;
        v.name = name; v.rn = rn; v.rm = rm; v.rd = rd; v.use3 = use3;
        v.ex_rd = ex_rd; v.mem_rd = mem_rd; v.wb_rd = wb_rd; v.en3 = en3;
        v.ex_ld = ex_ld; v.br = br; v.ea = ea; v.eb = eb; v.ec = ec; v.eflush = eflush;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ID_Rn = v.rn; ID_Rm = v.rm; ID_Rd = v.rd;
        {ID_use_Rn, ID_use_Rm, ID_use_Rd} = v.use3;
        EX_Rd = v.ex_rd; MEM_Rd = v.mem_rd; WB_Rd = v.wb_rd;
        {EX_RF_enable, MEM_RF_enable, WB_RF_enable} = v.en3;
        EX_load_instr = v.ex_ld; ID_branch_taken = v.br;
    endtask

    task automatic idle();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rd = 4'd0;
        ID_use_Rn = 1'b0; ID_use_Rm = 1'b0; ID_use_Rd = 1'b0;
        EX_Rd = 4'd0; MEM_Rd = 4'd0; WB_Rd = 4'd0;
        EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
        EX_load_instr = 1'b0; ID_branch_taken = 1'b0;
        MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        vecs.push_back(mk("ex_fwd_a",       4'd3, 4'd0, 4'd0,  3'b100, 4'd3,  4'd0, 4'd0,  3'b100, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("r15_a",          4'd15,4'd0, 4'd0,  3'b100, 4'd15, 4'd0, 4'd0,  3'b100, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("prio_ex_b",      4'd0, 4'd5, 4'd0,  3'b010, 4'd5,  4'd5, 4'd5,  3'b111, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
        vecs.push_back(mk("prio_mem_b",     4'd0, 4'd5, 4'd0,  3'b010, 4'd5,  4'd5, 4'd5,  3'b011, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0));
        vecs.push_back(mk("wb_c",           4'd0, 4'd0, 4'd7,  3'b001, 4'd0,  4'd0, 4'd7,  3'b001, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0));
        vecs.push_back(mk("unused_a",       4'd3, 4'd0, 4'd0,  3'b000, 4'd3,  4'd3, 4'd3,  3'b111, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("exload_nomatch", 4'd4, 4'd6, 4'd0,  3'b010, 4'd4,  4'd6, 4'd0,  3'b110, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0));
        vecs.push_back(mk("mem_dis_wb",     4'd8, 4'd0, 4'd0,  3'b100, 4'd0,  4'd8, 4'd8,  3'b001, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("branch",         4'd0, 4'd0, 4'd0,  3'b000, 4'd0,  4'd0, 4'd0,  3'b000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk("mixed",          4'd1, 4'd2, 4'd3,  3'b111, 4'd1,  4'd2, 4'd3,  3'b111, 1'b0, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0));
        vecs.push_back(mk("exload_r15",     4'd15,4'd0, 4'd0,  3'b100, 4'd15, 4'd0, 4'd0,  3'b100, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("wb_r15_c",       4'd0, 4'd0, 4'd15, 3'b001, 4'd0,  4'd0, 4'd15, 3'b001, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));

        // Reset state, with a forwarding match present on the inputs.
        R_n = 1'b0;
        idle();
        ID_Rn = 4'd3; ID_use_Rn = 1'b1; EX_Rd = 4'd3; EX_RF_enable = 1'b1;
        #3;
        check("rst_le", le_vec, LE_RESET);
        check("rst_flush", IF_ID_flush, 1'b0);
        check("rst_fwd_a", fwd_A, 2'b00);
        check("rst_mem_error", mem_error, 1'b0);
        tick();
        R_n = 1'b1;
        idle();
        tick();

        // Table of single-cycle RUN-state vectors.
        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            check({vecs[i].name, "_fwd_a"}, fwd_A, vecs[i].ea);
            check({vecs[i].name, "_fwd_b"}, fwd_B, vecs[i].eb);
            check({vecs[i].name, "_fwd_c"}, fwd_C, vecs[i].ec);
            check({vecs[i].name, "_flush"}, IF_ID_flush, vecs[i].eflush);
            check({vecs[i].name, "_le"}, le_vec, LE_RUN);
            tick();
        end
        idle();
        tick();

        // Load-use: one bubble, then the consumer forwards from MEM.
        EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd2;
        ID_Rm = 4'd2; ID_use_Rm = 1'b1;
        #1;
        check("lu_stall_le", le_vec, LE_STALL);
        check("lu_stall_flush", IF_ID_flush, 1'b0);
        tick();
        EX_load_instr = 1'b0; EX_RF_enable = 1'b0; EX_Rd = 4'd0;
        MEM_Rd = 4'd2; MEM_RF_enable = 1'b1;
        #1;
        check("lu_after_le", le_vec, LE_RUN);
        check("lu_after_fwd_b", fwd_B, 2'b10);
        tick();
        idle();
        #1;
        check("lu_back_run_le", le_vec, LE_RUN);
        tick();

        // Branch coincident with load-use: stall first, flush next cycle.
        EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd2;
        ID_Rm = 4'd2; ID_use_Rm = 1'b1; ID_branch_taken = 1'b1;
        #1;
        check("br_lu_le", le_vec, LE_STALL);
        check("br_lu_flush", IF_ID_flush, 1'b0);
        tick();
        EX_load_instr = 1'b0; EX_RF_enable = 1'b0;
        #1;
        check("br_next_le", le_vec, LE_RUN);
        check("br_next_flush", IF_ID_flush, 1'b1);
        tick();
        idle();
        #1;
        check("br_clear_flush", IF_ID_flush, 1'b0);
        tick();

        // Memory busy for 4 cycles, ready on the 5th.
        MEM_req = 1'b1; MEM_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mw4_freeze_%0d", i), le_vec, LE_FREEZE);
            tick();
        end
        MEM_ready = 1'b1;
        #1;
        check("mw4_release_le", le_vec, LE_RUN);
        tick();
        MEM_req = 1'b0; MEM_ready = 1'b0;
        #1;
        check("mw4_run_le", le_vec, LE_RUN);
        check("mw4_mem_error", mem_error, 1'b0);
        tick();

        // Reset asserted mid-wait takes effect without a clock edge.
        MEM_req = 1'b1; MEM_ready = 1'b0;
        tick();
        tick();
        #1;
        check("rmw_frozen", le_vec, LE_FREEZE);
        #1;
        R_n = 1'b0;
        #1;
        check("rmw_le", le_vec, LE_RESET);
        check("rmw_flush", IF_ID_flush, 1'b0);
        MEM_req = 1'b0;
        #1;
        R_n = 1'b1;
        tick();
        #1;
        check("rmw_run_le", le_vec, LE_RUN);
        tick();

        // Timeout: ready never comes; count frozen cycles (counter must start at 0).
        MEM_req = 1'b1; MEM_ready = 1'b0;
        n = 0;
        #1;
        while ((le_vec == LE_FREEZE) && (n < 40)) begin
            tick();
            #1;
            n++;
        end
        check("to_wait_cycles", n, 15);
        check("to_release_le", le_vec, LE_RUN);
        check("to_err_before_edge", mem_error, 1'b0);
        MEM_req = 1'b0;
        tick();
        #1;
        check("to_mem_error_set", mem_error, 1'b1);
        check("to_run_le", le_vec, LE_RUN);
        for (int i = 0; i < 3; i++) tick();
        check("to_mem_error_sticky", mem_error, 1'b1);
        R_n = 1'b0;
        #1;
        check("to_mem_error_cleared", mem_error, 1'b0);
        #2;
        R_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
